saxi_full_v1_0_s00_axi: RTL and testbench

SAXI_FULL_V1_0_S00_AXI -- requirements
Module: saxi_full_v1_0_s00_axi

---
 rtl/saxi_pkg.sv | 20 ++
 rtl/axi_burst_addr_gen.sv | 33 +++
 rtl/saxi_full_v1_0_s00_axi.sv | 207 ++++++++++++++++++++
 tb/tb_saxi_full_v1_0_s00_axi.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/saxi_pkg.sv
// Shared AXI burst/response encodings and FSM state types for the AXI4 full slave.
package saxi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat byte address for FIXED / INCR / WRAP bursts; reserved burst type steps like INCR.
module axi_burst_addr_gen
    import saxi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    localparam int LSB = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    assign incr_addr = addr + STEP;
    // Legal wrap lengths are 2/4/8/16 beats, so (len+1)*bytes-1 is a contiguous low mask.
    assign wrap_mask = (ADDR_WIDTH'(len) << LSB) | (STEP - 1'b1);

    always_comb begin
        next_addr = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/saxi_full_v1_0_s00_axi.sv
// AXI4 full slave backed by a word-addressed memory; independent read and write burst FSMs.
module saxi_full_v1_0_s00_axi
    import saxi_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH     = 1,
    parameter int C_S_AXI_DATA_WIDTH   = 128,
    parameter int C_S_AXI_ADDR_WIDTH   = 32,
    parameter int C_S_AXI_AWUSER_WIDTH = 0,
    parameter int C_S_AXI_ARUSER_WIDTH = 0,
    parameter int C_S_AXI_WUSER_WIDTH  = 0,
    parameter int C_S_AXI_RUSER_WIDTH  = 0,
    parameter int C_S_AXI_BUSER_WIDTH  = 0,
    parameter int C_S_AXI_MEM_LOG2     = 20
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]            S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [7:0]                             S_AXI_AWLEN,
    input  logic [2:0]                             S_AXI_AWSIZE,
    input  logic [1:0]                             S_AXI_AWBURST,
    input  logic                                   S_AXI_AWLOCK,
    input  logic [3:0]                             S_AXI_AWCACHE,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic [3:0]                             S_AXI_AWQOS,
    input  logic [3:0]                             S_AXI_AWREGION,
    input  logic [((C_S_AXI_AWUSER_WIDTH > 0) ? C_S_AXI_AWUSER_WIDTH : 1)-1:0] S_AXI_AWUSER,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WLAST,
    input  logic [((C_S_AXI_WUSER_WIDTH > 0) ? C_S_AXI_WUSER_WIDTH : 1)-1:0] S_AXI_WUSER,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]            S_AXI_BID,
    output logic [1:0]                             S_AXI_BRESP,
    output logic [((C_S_AXI_BUSER_WIDTH > 0) ? C_S_AXI_BUSER_WIDTH : 1)-1:0] S_AXI_BUSER,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]            S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [7:0]                             S_AXI_ARLEN,
    input  logic [2:0]                             S_AXI_ARSIZE,
    input  logic [1:0]                             S_AXI_ARBURST,
    input  logic                                   S_AXI_ARLOCK,
    input  logic [3:0]                             S_AXI_ARCACHE,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic [3:0]                             S_AXI_ARQOS,
    input  logic [3:0]                             S_AXI_ARREGION,
    input  logic [((C_S_AXI_ARUSER_WIDTH > 0) ? C_S_AXI_ARUSER_WIDTH : 1)-1:0] S_AXI_ARUSER,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]            S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RLAST,
    output logic [((C_S_AXI_RUSER_WIDTH > 0) ? C_S_AXI_RUSER_WIDTH : 1)-1:0] S_AXI_RUSER,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY
);

    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int LSB   = $clog2(DW / 8);
    localparam int DEPTH = 1 << C_S_AXI_MEM_LOG2;

    logic [DW-1:0] mem [0:DEPTH-1] = '{default: '0};

    w_state_t                    w_state;
    logic [AW-1:0]               aw_addr, aw_next;
    logic [7:0]                  aw_len;
    logic [1:0]                  aw_burst;
    logic [C_S_AXI_ID_WIDTH-1:0] aw_id;
    logic                        w_fire;

    r_state_t                    r_state;
    logic [AW-1:0]               ar_addr, ar_next;
    logic [7:0]                  ar_len, r_beat;
    logic [1:0]                  ar_burst;

    axi_burst_addr_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_waddr (
        .addr(aw_addr), .len(aw_len), .burst(aw_burst), .next_addr(aw_next)
    );

    axi_burst_addr_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_raddr (
        .addr(ar_addr), .len(ar_len), .burst(ar_burst), .next_addr(ar_next)
    );

    assign w_fire = (w_state == W_DATA) && S_AXI_WVALID && S_AXI_WREADY;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= '0;
            aw_addr       <= '0;
            aw_len        <= '0;
            aw_burst      <= '0;
            aw_id         <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    // AWREADY is a one-cycle pulse; the handshake edge latches the command.
                    if (S_AXI_AWREADY && S_AXI_AWVALID) begin
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        aw_addr       <= S_AXI_AWADDR;
                        aw_len        <= S_AXI_AWLEN;
                        aw_burst      <= S_AXI_AWBURST;
                        aw_id         <= S_AXI_AWID;
                        w_state       <= W_DATA;
                    end else begin
                        S_AXI_AWREADY <= S_AXI_AWVALID;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        aw_addr <= aw_next;
                        if (S_AXI_WLAST) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BID    <= aw_id;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        w_state      <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Memory survives reset; only the in-flight burst is dropped.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESET && w_fire) begin
            for (int i = 0; i < DW / 8; i++) begin
                if (S_AXI_WSTRB[i]) begin
                    mem[aw_addr[LSB +: C_S_AXI_MEM_LOG2]][i*8 +: 8] <= S_AXI_WDATA[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RID     <= '0;
            ar_addr       <= '0;
            ar_len        <= '0;
            ar_burst      <= '0;
            r_beat        <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RID     <= S_AXI_ARID;
                        ar_addr       <= S_AXI_ARADDR;
                        ar_len        <= S_AXI_ARLEN;
                        ar_burst      <= S_AXI_ARBURST;
                        r_beat        <= '0;
                        r_state       <= R_DATA;
                    end else begin
                        S_AXI_ARREADY <= S_AXI_ARVALID;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RVALID && S_AXI_RREADY) begin
                        if (S_AXI_RLAST) begin
                            S_AXI_RVALID <= 1'b0;
                            r_state      <= R_IDLE;
                        end else begin
                            ar_addr <= ar_next;
                            r_beat  <= r_beat + 8'd1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_RDATA = mem[ar_addr[LSB +: C_S_AXI_MEM_LOG2]];
    assign S_AXI_RLAST = S_AXI_RVALID && (r_beat == ar_len);
    assign S_AXI_RRESP = RESP_OKAY;
    assign S_AXI_BRESP = RESP_OKAY;
    assign S_AXI_BUSER = '0;
    assign S_AXI_RUSER = '0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, S_AXI_AWSIZE, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT,
                             S_AXI_AWQOS, S_AXI_AWREGION, S_AXI_AWUSER, S_AXI_WUSER,
                             S_AXI_ARSIZE, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT,
                             S_AXI_ARQOS, S_AXI_ARREGION, S_AXI_ARUSER};

endmodule

// File: tb/tb_saxi_full_v1_0_s00_axi.sv
// Directed bench for the AXI4 full slave: byte-level memory model feeds a read scoreboard queue.
module tb_saxi_full_v1_0_s00_axi;

    logic         clk = 1'b0;
    logic         areset = 1'b1;
    logic [0:0]   awid = '0, bid, arid = '0, rid;
    logic [31:0]  awaddr = '0, araddr = '0;
    logic [7:0]   awlen = '0, arlen = '0;
    logic [1:0]   awburst = '0, arburst = '0, bresp, rresp;
    logic         awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic         bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic         rlast, rvalid, rready = 1'b0;
    logic [127:0] wdata = '0, rdata;
    logic [15:0]  wstrb = '0;
    logic [0:0]   buser, ruser;

    int vectors = 0;
    int errors  = 0;

    logic [127:0] model [int];
    logic [127:0] wq [$];
    logic [127:0] expq [$];

    always #5 clk = ~clk;

    saxi_full_v1_0_s00_axi #(.C_S_AXI_MEM_LOG2(10)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(3'd4),
        .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0),
        .S_AXI_AWQOS(4'd0), .S_AXI_AWREGION(4'd0), .S_AXI_AWUSER(1'b0),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WUSER(1'b0),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BUSER(buser), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(3'd4),
        .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0),
        .S_AXI_ARQOS(4'd0), .S_AXI_ARREGION(4'd0), .S_AXI_ARUSER(1'b0),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RUSER(ruser), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 4) & 32'h3FF);
    endfunction

    function automatic logic [31:0] next_a(input logic [31:0] a, input logic [7:0] len,
                                           input logic [1:0] burst);
        logic [31:0] span, base;
        case (burst)
            2'b00: return a;
            2'b10: begin
                span = (32'(len) + 32'd1) * 32'd16;
                base = a - (a % span);
                return base + ((a - base + 32'd16) % span);
            end
            default: return a + 32'd16;
        endcase
    endfunction

    function automatic logic [127:0] model_rd(input logic [31:0] a);
        return model.exists(widx(a)) ? model[widx(a)] : 128'd0;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [0:0] id, input logic [15:0] strb);
        logic [31:0]  a = addr;
        logic [127:0] w;
        int n;
        awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check("awready_rise", awready, 1'b1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wq[i]; wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 20) begin @(negedge clk); n++; end
            if (!wready) check("wready_timeout", wready, 1'b1);
            w = model_rd(a);
            for (int b = 0; b < 16; b++) if (strb[b]) w[b*8 +: 8] = wq[i][b*8 +: 8];
            model[widx(a)] = w;
            a = next_a(a, len, burst);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("bvalid_after_wlast", bvalid, 1'b1);
        check("bid", bid, id);
        check("bresp", bresp, 2'b00);
        @(negedge clk);
        check("bvalid_held", bvalid, 1'b1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_clear", bvalid, 1'b0);
        wq.delete();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [0:0] id, input bit toggle);
        logic [31:0]  a = addr;
        logic [127:0] pd = '0, e;
        logic         pl = 1'b0;
        bit           stalled = 0;
        int           n, beat;
        for (int i = 0; i <= int'(len); i++) begin
            expq.push_back(model_rd(a));
            a = next_a(a, len, burst);
        end
        araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        check("arready_rise", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        beat = 0; n = 0;
        while (beat <= int'(len) && n < 200) begin
            rready = toggle ? (n % 2 == 1) : 1'b1;
            if (stalled) begin
                check("rdata_stable", rdata, pd);
                check("rlast_stable", rlast, pl);
            end
            stalled = 0;
            if (rvalid && rready) begin
                e = expq.pop_front();
                check("rdata", rdata, e);
                check("rlast", rlast, beat == int'(len));
                check("rid", rid, id);
                check("rresp", rresp, 2'b00);
                beat++;
            end else if (rvalid) begin
                stalled = 1; pd = rdata; pl = rlast;
            end
            @(negedge clk);
            n++;
        end
        rready = 1'b0;
        if (beat <= int'(len)) check("read_beats_timeout", 128'(beat), 128'(int'(len) + 1));
        check("rvalid_after_last", rvalid, 1'b0);
        expq.delete();
    endtask

    initial begin
        awvalid = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_handshakes", {awready, wready, bvalid, arready, rvalid, rlast}, 6'd0);
        check("reset_ids_resps", {bid, rid, bresp, rresp}, 6'd0);
        awvalid = 1'b0;
        areset = 1'b0;
        repeat (3) @(negedge clk);
        check("awready_idle_low", awready, 1'b0);

        for (int k = 0; k < 16; k++) wq.push_back(128'(k));
        do_write(32'h1000, 8'd15, 2'b01, 1'b1, 16'hFFFF);
        do_read(32'h1000, 8'd15, 2'b01, 1'b1, 1'b0);

        wq.push_back({128{1'b1}});
        do_write(32'h0040, 8'd0, 2'b01, 1'b0, 16'hFFFF);
        wq.push_back(128'h11223344);
        do_write(32'h0040, 8'd0, 2'b01, 1'b1, 16'h000F);
        do_read(32'h0040, 8'd0, 2'b01, 1'b0, 1'b0);
        check("strb_model", model_rd(32'h0040), {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h11223344});

        do_read(32'h1000, 8'd15, 2'b01, 1'b0, 1'b1);

        wq.push_back(128'hA); wq.push_back(128'hB); wq.push_back(128'hC); wq.push_back(128'hD);
        do_write(32'h0020, 8'd3, 2'b00, 1'b0, 16'hFFFF);
        do_read(32'h0020, 8'd0, 2'b01, 1'b0, 1'b0);
        do_read(32'h0030, 8'd0, 2'b01, 1'b1, 1'b0);

        for (int k = 1; k <= 4; k++) wq.push_back(128'(k));
        do_write(32'h0030, 8'd3, 2'b10, 1'b1, 16'hFFFF);
        do_read(32'h0000, 8'd3, 2'b01, 1'b0, 1'b0);
        do_read(32'h0020, 8'd3, 2'b10, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
